// File: rtl/leb128_fetch_pkg.sv
// Shared types and constants for the LEB128 immediate fetch stage.
// State encodings, error codes and per-width byte limits.
package leb128_fetch_pkg;

  typedef enum logic [1:0] {
    LEB_IDLE   = 2'd0,
    LEB_FETCH  = 2'd1,
    LEB_DECODE = 2'd2,
    LEB_DONE   = 2'd3
  } leb_state_t;

  localparam logic [1:0] LEB_OK           = 2'd0;
  localparam logic [1:0] LEB_ERR_MEM      = 2'd1;
  localparam logic [1:0] LEB_ERR_OVERFLOW = 2'd2;

  localparam logic [3:0] LEB_MAX32 = 4'd5;
  localparam logic [3:0] LEB_MAX64 = 4'd10;
  localparam int         LEB_STEPS = 10;

  // Bits at and above position n set; zero once n reaches 64.
  function automatic logic [63:0] leb_mask(input logic [6:0] n);
    return ~((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/leb128_step.sv
// One LEB128 byte: merge 7 payload bits at 7k, sign-fill on the
// terminator and flag an out-of-range final byte.
module leb128_step
  import leb128_fetch_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [7:0]  b,
  input  logic [3:0]  k,
  input  logic        sgn,
  input  logic        wide,
  output logic [63:0] acc_next,
  output logic        last,
  output logic        bad
);

  logic [6:0]  sh;
  logic [6:0]  sh_end;
  logic [63:0] res;
  logic [3:0]  max_k;
  logic        chk;

  always_comb begin
    sh     = 7'(k) * 7'd7;
    sh_end = sh + 7'd7;
    res    = acc | ({57'd0, b[6:0]} << sh);
    if (sgn && !b[7] && b[6])
      res = res | leb_mask(sh_end);
    if (!wide)
      res[63:32] = '0;
    acc_next = res;
    last     = !b[7];
    max_k    = wide ? LEB_MAX64 - 4'd1 : LEB_MAX32 - 4'd1;
    chk      = 1'b0;
    // Final byte may only carry bits that still fit the target type.
    unique case (1'b1)
      !wide && !sgn: chk = b[6:4] == 3'd0;
      !wide &&  sgn: chk = b[6:3] == 4'h0 || b[6:3] == 4'hF;
       wide && !sgn: chk = b[6:1] == 6'd0;
      default:       chk = b[6:0] == 7'h00 || b[6:0] == 7'h7F;
    endcase
    bad = (k == max_k) && (b[7] || !chk);
  end

endmodule

// File: rtl/leb128_fetch.sv
// LEB128 immediate fetch/decode stage between genrom and the decoder.
// LEB128_FAST_EN selects single-cycle parallel decode instead of serial.
module leb128_fetch
  import leb128_fetch_pkg::*;
#(
  parameter int MEM_DEPTH = 5,
  parameter int MEM_EXTRA = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic [MEM_DEPTH:0]         req_addr,
  input  logic                       req_signed,
  input  logic                       req_wide,
  output logic [MEM_DEPTH:0]         mem_addr,
  output logic [MEM_EXTRA-1:0]       mem_extra,
  input  logic [2**MEM_EXTRA*8-1:0]  mem_data,
  input  logic                       mem_error,
  output logic                       busy,
  output logic                       done,
  output logic [63:0]                value,
  output logic [3:0]                 len,
  output logic [1:0]                 error
);

  localparam logic [MEM_EXTRA-1:0] EXTRA_N =
    MEM_EXTRA'(LEB_MAX32 - 4'd1);
  localparam logic [MEM_EXTRA-1:0] EXTRA_W =
    MEM_EXTRA'(LEB_MAX64 - 4'd1);

  leb_state_t  state;
  logic        sgn_q;
  logic        wide_q;
  logic        first;
  logic        stop;
  logic        stop_bad;
  logic [63:0] stop_val;
  logic [3:0]  stop_len;

`ifdef LEB128_FAST_EN
  logic [63:0]          f_acc [0:LEB_STEPS];
  logic [LEB_STEPS-1:0] f_last;
  logic [LEB_STEPS-1:0] f_bad;

  assign f_acc[0] = '0;
  assign first    = 1'b1;

  for (genvar i = 0; i < LEB_STEPS; i++) begin : g_step
    leb128_step u_step (
      .acc      (f_acc[i]),
      .b        (mem_data[8*i +: 8]),
      .k        (4'(i)),
      .sgn      (sgn_q),
      .wide     (wide_q),
      .acc_next (f_acc[i+1]),
      .last     (f_last[i]),
      .bad      (f_bad[i])
    );
  end

  // First byte that terminates or overflows wins.
  always_comb begin
    stop     = 1'b0;
    stop_bad = 1'b0;
    stop_val = '0;
    stop_len = '0;
    for (int i = 0; i < LEB_STEPS; i++) begin
      if (!stop && (f_last[i] || f_bad[i])) begin
        stop     = 1'b1;
        stop_bad = f_bad[i];
        stop_val = f_acc[i+1];
        stop_len = 4'(i + 1);
      end
    end
  end
`else
  logic [63:0] acc_q;
  logic [3:0]  k_q;
  logic [7:0]  s_byte;
  logic        s_last;
  logic        s_bad;

  assign s_byte = 8'(mem_data >> {k_q, 3'b000});

  leb128_step u_step (
    .acc      (acc_q),
    .b        (s_byte),
    .k        (k_q),
    .sgn      (sgn_q),
    .wide     (wide_q),
    .acc_next (stop_val),
    .last     (s_last),
    .bad      (s_bad)
  );

  assign first    = k_q == 4'd0;
  assign stop     = s_last | s_bad;
  assign stop_bad = s_bad;
  assign stop_len = k_q + 4'd1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LEB_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      value     <= '0;
      len       <= '0;
      error     <= LEB_OK;
      mem_addr  <= '0;
      mem_extra <= '0;
      sgn_q     <= 1'b0;
      wide_q    <= 1'b0;
`ifndef LEB128_FAST_EN
      acc_q     <= '0;
      k_q       <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        LEB_IDLE: begin
          if (req) begin
            state     <= LEB_FETCH;
            busy      <= 1'b1;
            sgn_q     <= req_signed;
            wide_q    <= req_wide;
            mem_addr  <= req_addr;
            mem_extra <= req_wide ? EXTRA_W : EXTRA_N;
`ifndef LEB128_FAST_EN
            acc_q     <= '0;
            k_q       <= '0;
`endif
          end
        end
        LEB_FETCH: state <= LEB_DECODE;
        LEB_DECODE: begin
          if (first && mem_error) begin
            state <= LEB_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            value <= '0;
            len   <= '0;
            error <= LEB_ERR_MEM;
          end else if (stop) begin
            state <= LEB_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            value <= stop_bad ? 64'd0 : stop_val;
            len   <= stop_len;
            error <= stop_bad ? LEB_ERR_OVERFLOW : LEB_OK;
          end
`ifndef LEB128_FAST_EN
          else begin
            acc_q <= stop_val;
            k_q   <= k_q + 4'd1;
          end
`endif
        end
        LEB_DONE: state <= LEB_IDLE;
        default:  state <= LEB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_fetch.sv
// Bench for leb128_fetch: genrom model, reference LEB128 decoder,
// per-cycle output monitor and directed vectors.
module tb_leb128_fetch;

  localparam int ROM_UPPER = 47;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req = 1'b0;
  logic [5:0]   req_addr = '0;
  logic         req_signed = 1'b0;
  logic         req_wide = 1'b0;
  logic [5:0]   mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data = '0;
  logic         mem_error = 1'b0;
  logic         busy;
  logic         done;
  logic [63:0]  value;
  logic [3:0]   len;
  logic [1:0]   error;

  logic [7:0]   rom [64];

  int checks = 0;
  int failures = 0;
  int nc = 0;

  bit          pending = 1'b0;
  logic [63:0] exp_val;
  logic [3:0]  exp_len;
  logic [1:0]  exp_err;
  logic [5:0]  exp_addr;
  logic        exp_wide;
  int          exp_issue;
  int          exp_lat;
  string       exp_name;

  leb128_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .req_signed (req_signed),
    .req_wide   (req_wide),
    .mem_addr   (mem_addr),
    .mem_extra  (mem_extra),
    .mem_data   (mem_data),
    .mem_error  (mem_error),
    .busy       (busy),
    .done       (done),
    .value      (value),
    .len        (len),
    .error      (error)
  );

  always #5 clk = ~clk;

  // genrom: one-cycle registered read, error past the upper bound
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++)
      mem_data[8*k +: 8] <= (int'(mem_addr) + k < 64) ?
                            rom[int'(mem_addr) + k] : 8'h00;
    mem_error <= int'(mem_addr) > ROM_UPPER;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req_v);
    end
  endtask

  // Reference decode: full-precision value, then a range test.
  task automatic model(input logic [5:0] a, input logic s, input logic w,
                       output logic [63:0] v, output logic [3:0] n,
                       output logic [1:0] e);
    logic [127:0] raw;
    logic [127:0] top;
    logic [127:0] ones;
    logic [7:0]   b;
    int           mx;
    int           cnt;
    int           sh;
    bit           term;
    v = '0; n = '0; e = 2'd0;
    if (int'(a) > ROM_UPPER) begin
      e = 2'd1;
      return;
    end
    mx = w ? 10 : 5;
    raw = '0; term = 1'b0; cnt = 0; b = '0;
    for (int i = 0; i < mx && !term; i++) begin
      b = (int'(a) + i < 64) ? rom[int'(a) + i] : 8'h00;
      raw = raw | (128'(b[6:0]) << (7 * i));
      cnt = i + 1;
      term = !b[7];
    end
    n = 4'(cnt);
    if (!term) begin
      e = 2'd2;
      return;
    end
    if (s && b[6])
      raw = raw | ~((128'd1 << (7 * cnt)) - 128'd1);
    sh = (w ? 64 : 32) - (s ? 1 : 0);
    top = raw >> sh;
    ones = {128{1'b1}} >> sh;
    if (!(top == '0 || (s && top == ones))) begin
      e = 2'd2;
      return;
    end
    v = w ? raw[63:0] : {32'h0, raw[31:0]};
  endtask

  // Single compare process: done results, latency, busy and ROM request.
  always @(negedge clk) begin
    nc++;
    if (!reset) begin
      if (done) begin
        if (!pending) begin
          chk("spurious_done", 64'(done), 64'd0);
        end else begin
          chk({exp_name, "_value"}, value, exp_val);
          chk({exp_name, "_len"}, 64'(len), 64'(exp_len));
          chk({exp_name, "_error"}, 64'(error), 64'(exp_err));
          chk({exp_name, "_latency"}, 64'(nc - exp_issue - 1),
              64'(exp_lat));
          chk({exp_name, "_busy_at_done"}, 64'(busy), 64'd0);
          pending = 1'b0;
        end
      end else if (pending && nc >= exp_issue + 2) begin
        chk({exp_name, "_busy"}, 64'(busy), 64'd1);
        chk({exp_name, "_mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        chk({exp_name, "_mem_extra"}, 64'(mem_extra),
            exp_wide ? 64'd9 : 64'd4);
      end
    end
  end

  // Raises req for the accepting edge; leaves req high if hold is set.
  task automatic issue(input logic [5:0] a, input logic s, input logic w,
                       input string nm, input bit hold);
    logic [63:0] mv;
    logic [3:0]  ml;
    logic [1:0]  me;
    model(a, s, w, mv, ml, me);
    @(posedge clk);
    #2;
    req_addr = a; req_signed = s; req_wide = w; req = 1'b1;
    exp_val = mv; exp_len = ml; exp_err = me;
    exp_addr = a; exp_wide = w; exp_name = nm; exp_issue = nc;
`ifdef LEB128_FAST_EN
    exp_lat = 3;
`else
    exp_lat = (me == 2'd1 ? 1 : int'(ml)) + 2;
`endif
    pending = 1'b1;
    @(posedge clk);
    #2;
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (pending && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (pending) begin
      failures++;
      $display("FAIL %s_timeout: got no done, required done within 40", nm);
      pending = 1'b0;
    end
  endtask

  task automatic run(input logic [5:0] a, input logic s, input logic w,
                     input logic [63:0] ev, input logic [3:0] el,
                     input logic [1:0] ee, input string nm);
    logic [63:0] mv;
    logic [3:0]  ml;
    logic [1:0]  me;
    model(a, s, w, mv, ml, me);
    chk({nm, "_model_value"}, mv, ev);
    chk({nm, "_model_len"}, 64'(ml), 64'(el));
    chk({nm, "_model_error"}, 64'(me), 64'(ee));
    issue(a, s, w, nm, 1'b0);
    wait_done(nm);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[0] = 8'hE5; rom[1] = 8'h8E; rom[2] = 8'h26;
    rom[4] = 8'h7F;
    rom[5] = 8'h80; rom[6] = 8'h7F;
    for (int i = 8; i < 17; i++) rom[i] = 8'h80;
    rom[17] = 8'h7F;
    for (int i = 18; i < 22; i++) rom[i] = 8'hFF;
    rom[22] = 8'h0F;
    for (int i = 23; i < 27; i++) rom[i] = 8'hFF;
    rom[27] = 8'h7F;
    for (int i = 28; i < 33; i++) rom[i] = 8'h80;
    for (int i = 33; i < 36; i++) rom[i] = 8'h80;
    rom[36] = 8'h05;
    rom[37] = 8'h05;
    for (int i = 42; i < 46; i++) rom[i] = 8'h80;
    rom[46] = 8'h78;

    #3;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_value", value, 64'd0);
    chk("reset_len", 64'(len), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_mem_extra", 64'(mem_extra), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    run(6'd0,  1'b0, 1'b0, 64'd624485, 4'd3, 2'd0, "u32_e58e26");
    run(6'd4,  1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd1, 2'd0, "s32_7f");
    run(6'd5,  1'b1, 1'b0, 64'h0000_0000_FFFF_FF80, 4'd2, 2'd0, "s32_807f");
    run(6'd8,  1'b1, 1'b1, 64'h8000_0000_0000_0000, 4'd10, 2'd0, "s64_min");
    run(6'd18, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd5, 2'd0, "u32_max");
    run(6'd23, 1'b0, 1'b0, 64'd0, 4'd5, 2'd2, "u32_lastbyte_ovf");
    run(6'd28, 1'b0, 1'b0, 64'd0, 4'd5, 2'd2, "u32_noterm_ovf");
    run(6'd50, 1'b0, 1'b0, 64'd0, 4'd0, 2'd1, "oob_mem_err");
    run(6'd0,  1'b0, 1'b1, 64'd624485, 4'd3, 2'd0, "u64_e58e26");
    run(6'd42, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 4'd5, 2'd0, "s32_min");

    // Abort in DECODE: no done afterwards, outputs idle next cycle
    issue(6'd33, 1'b0, 1'b0, "reset_abort", 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    pending = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    // req kept high with other operands through busy and DONE
    issue(6'd37, 1'b0, 1'b0, "u32_05_ignore", 1'b1);
    req_addr = 6'd4;
    req_signed = 1'b1;
    repeat (3) @(posedge clk);
    #2 req = 1'b0;
    wait_done("u32_05_ignore");
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
